// File: rtl/job_arb_fifo_pkg.sv
// Shared job descriptor type and width helpers for the job arbiter FIFO slice.
package job_pkg;

    localparam int JOB_DW = 128;

    typedef logic [JOB_DW-1:0] job_t;

    // Channel-index width; a single channel still needs a 1-bit index.
    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/job_arb_fifo_if.sv
// Handshake bundle: per-channel push side with flush, one arbitrated job output, occupancy status.
interface job_arb_fifo_if import job_pkg::*; #(
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = JOB_DW
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cw_of(NUM_CH);

    logic [NUM_CH-1:0]            s_valid;
    logic [NUM_CH-1:0]            s_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] s_data;
    logic [NUM_CH-1:0]            flush;

    logic                         m_valid;
    logic                         m_ready;
    logic [DATA_WIDTH-1:0]        m_data;
    logic [CW-1:0]                m_ch;

    logic [NUM_CH*(AW+1)-1:0]     level;
    logic [NUM_CH-1:0]            almost_full;
    logic [NUM_CH-1:0]            empty;

    modport master (
        output s_valid, s_data, flush, m_ready,
        input  s_ready, m_valid, m_data, m_ch, level, almost_full, empty
    );

    modport slave (
        input  s_valid, s_data, flush, m_ready,
        output s_ready, m_valid, m_data, m_ch, level, almost_full, empty
    );

endinterface

// File: rtl/job_arb_fifo_ch.sv
// One job channel: DEPTH-entry FIFO with flush; head visible combinationally, one-edge push/pop.
// Push refused when full or flushing; pop is ignored when empty or flushing.
module job_fifo_ch import job_pkg::*; #(
    parameter int  DEPTH      = 16,
    parameter int  DATA_WIDTH = JOB_DW,
    parameter int  AF_THRESH  = 12,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_vld_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    output logic                  push_rdy_o,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_dat_o,
    input  logic                  flush_i,
    output logic [AW:0]           level_o,
    output logic                  almost_full_o,
    output logic                  empty_o
);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           level_q, level_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Readiness uses the registered level only, so a same-edge pop never frees a full slot.
    assign push_rdy_o = (level_q != LVL_FULL) && !flush_i;
    assign push_ok    = push_vld_i && push_rdy_o;
    assign pop_ok     = pop_i && (level_q != '0) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o    = mem_q[rd_ptr_q];
    assign level_o       = level_q;
    assign almost_full_o = (level_q >= LVL_AF);
    assign empty_o       = (level_q == '0);

endmodule

// File: rtl/job_arb_fifo.sv
// NUM_CH job FIFOs merged by a round-robin arbiter into one registered output stage.
// Push to issue: one edge into the FIFO, one into the stage; stage holds while m_ready is low.
module job_arb_fifo import job_pkg::*; #(
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = JOB_DW,
    parameter int AF_THRESH  = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    job_arb_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cw_of(NUM_CH);

    logic [NUM_CH-1:0]        ch_rdy;
    logic [NUM_CH-1:0]        ch_af;
    logic [NUM_CH-1:0]        ch_empty;
    logic [NUM_CH-1:0]        ch_elig;
    logic [NUM_CH-1:0]        ch_pop;
    logic [DATA_WIDTH-1:0]    ch_dat [NUM_CH];
    logic [AW:0]              ch_lvl [NUM_CH];
    logic [NUM_CH*(AW+1)-1:0] lvl_flat;

    logic                     load;
    logic                     gnt_vld;
    logic [CW-1:0]            gnt_ch;
    logic [CW-1:0]            cand;

    logic [CW-1:0]            rr_ptr_q, rr_ptr_d;
    logic                     m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
    logic [CW-1:0]            m_ch_q, m_ch_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        job_fifo_ch #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .AF_THRESH  (AF_THRESH)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .push_vld_i    (bus.s_valid[c]),
            .push_dat_i    (bus.s_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .push_rdy_o    (ch_rdy[c]),
            .pop_i         (ch_pop[c]),
            .head_dat_o    (ch_dat[c]),
            .flush_i       (bus.flush[c]),
            .level_o       (ch_lvl[c]),
            .almost_full_o (ch_af[c]),
            .empty_o       (ch_empty[c])
        );
    end

    assign ch_elig = ~ch_empty & ~bus.flush;
    assign load    = !m_valid_q || bus.m_ready;

    // Walk the channels starting just after the last winner, wrapping at NUM_CH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = rr_ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (cand == CW'(NUM_CH-1)) ? '0 : cand + CW'(1);
            if (!gnt_vld && ch_elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    always_comb begin
        ch_pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_pop[c] = load && gnt_vld && (gnt_ch == CW'(c));
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ch_d    = m_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (load) begin
            m_valid_d = gnt_vld;
            if (gnt_vld) begin
                m_data_d = ch_dat[gnt_ch];
                m_ch_d   = gnt_ch;
                rr_ptr_d = gnt_ch;
            end
        end
    end

    // Reset pointer sits on the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= CW'(NUM_CH-1);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
        end
    end

    always_comb begin
        lvl_flat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lvl_flat[c*(AW+1) +: AW+1] = ch_lvl[c];
        end
    end

    assign bus.s_ready     = ch_rdy;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_ch        = m_ch_q;
    assign bus.level       = lvl_flat;
    assign bus.almost_full = ch_af;
    assign bus.empty       = ch_empty;

endmodule
